// File: rtl/wf_pending_scheduler_if.sv
// Handshake bundle between wavefront-ready producers, the pending scoreboard
// and the issue stage.
interface wf_pending_scheduler_if #(
  parameter int NUM_WF      = 40,
  parameter int WF_ID_WIDTH = 6
);
  logic                   set_valid;
  logic [WF_ID_WIDTH-1:0] set_wf_id;
  logic                   flush_valid;
  logic [WF_ID_WIDTH-1:0] flush_wf_id;
  logic                   issue_ready;
  logic                   issue_valid;
  logic [WF_ID_WIDTH-1:0] issue_wf_id;
  logic [NUM_WF-1:0]      pending_vec;
  logic [WF_ID_WIDTH:0]   pending_count;

  modport master (
    output set_valid, set_wf_id, flush_valid, flush_wf_id, issue_ready,
    input  issue_valid, issue_wf_id, pending_vec, pending_count
  );

  modport slave (
    input  set_valid, set_wf_id, flush_valid, flush_wf_id, issue_ready,
    output issue_valid, issue_wf_id, pending_vec, pending_count
  );
endinterface

// File: rtl/wf_pending_scheduler.sv
// Per-wavefront pending scoreboard with a round-robin pick into a registered
// valid/ready issue port. Set dominates flush and load on the same bit.
module wf_pending_scheduler #(
  parameter int NUM_WF      = 40,
  parameter int WF_ID_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  wf_pending_scheduler_if.slave  bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [WF_ID_WIDTH-1:0] LAST_ID  = WF_ID_WIDTH'(NUM_WF - 1);
  localparam logic [WF_ID_WIDTH:0]   NUM_WF_L = (WF_ID_WIDTH + 1)'(NUM_WF);

  logic [0:0]             state_q, state_n;
  logic [WF_ID_WIDTH-1:0] issue_id_q, issue_id_n;
  logic [WF_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_n;
  logic [NUM_WF-1:0]      pend_q, pend_n;
  logic [WF_ID_WIDTH:0]   count_q;

  logic [NUM_WF-1:0]      set_hit, flush_hit, load_hit;
  logic                   flush_held, handshake, load_en;
  logic [WF_ID_WIDTH-1:0] rr_base;
  logic [WF_ID_WIDTH:0]   pick;
  logic                   pick_found;
  logic [WF_ID_WIDTH-1:0] pick_id;

  function automatic logic [NUM_WF-1:0] onehot(input logic v,
                                               input logic [WF_ID_WIDTH-1:0] id);
    logic [NUM_WF-1:0] one;
    one = {{(NUM_WF-1){1'b0}}, 1'b1};
    // Ids past the last slot decode to nothing, so they are silently ignored.
    return (v && (id <= LAST_ID)) ? (one << id) : '0;
  endfunction

  function automatic logic [WF_ID_WIDTH:0] popcount(input logic [NUM_WF-1:0] v);
    logic [WF_ID_WIDTH:0] c;
    logic [NUM_WF-1:0]    t;
    c = '0;
    t = v;
    for (int k = 0; k < NUM_WF; k++) begin
      c = c + (WF_ID_WIDTH + 1)'(t[0]);
      t = t >> 1;
    end
    return c;
  endfunction

  function automatic logic [WF_ID_WIDTH-1:0] wrap_inc(input logic [WF_ID_WIDTH-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // Returns {found, id}: rotate so that base lands at bit 0, take the lowest
  // set bit, then map the offset back into slot numbering.
  function automatic logic [WF_ID_WIDTH:0] rr_pick(input logic [NUM_WF-1:0] v,
                                                   input logic [WF_ID_WIDTH-1:0] base);
    logic [2*NUM_WF-1:0]    dbl;
    logic [NUM_WF-1:0]      rot;
    logic                   f;
    logic [WF_ID_WIDTH-1:0] off;
    logic [WF_ID_WIDTH:0]   sum;
    dbl = {v, v} >> base;
    rot = dbl[NUM_WF-1:0];
    f   = 1'b0;
    off = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      if (!f && rot[0]) begin
        f   = 1'b1;
        off = WF_ID_WIDTH'(k);
      end
      rot = rot >> 1;
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NUM_WF_L) sum = sum - NUM_WF_L;
    return {f, sum[WF_ID_WIDTH-1:0]};
  endfunction

  always_comb begin
    set_hit    = onehot(bus.set_valid, bus.set_wf_id);
    flush_hit  = onehot(bus.flush_valid, bus.flush_wf_id);
    // Flushing the held id beats a same-cycle ready: nothing is issued.
    flush_held = (state_q == ST_HOLD) && bus.flush_valid && (bus.flush_wf_id == issue_id_q);
    handshake  = (state_q == ST_HOLD) && bus.issue_ready && !flush_held;
    rr_base    = handshake ? wrap_inc(issue_id_q) : rr_ptr_q;
    load_en    = (state_q == ST_EMPTY) || handshake;
    pick       = rr_pick(pend_q, rr_base);
    pick_found = pick[WF_ID_WIDTH];
    pick_id    = pick[WF_ID_WIDTH-1:0];
    load_hit   = onehot(load_en && pick_found, pick_id);
    pend_n     = set_hit | (pend_q & ~(flush_hit | load_hit));

    state_n    = state_q;
    issue_id_n = issue_id_q;
    rr_ptr_n   = handshake ? rr_base : rr_ptr_q;
    if (flush_held) begin
      state_n = ST_EMPTY;
    end else if (load_en) begin
      if (pick_found) begin
        state_n    = ST_HOLD;
        issue_id_n = pick_id;
      end else begin
        state_n = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      issue_id_q <= '0;
      rr_ptr_q   <= '0;
      pend_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_n;
      issue_id_q <= issue_id_n;
      rr_ptr_q   <= rr_ptr_n;
      pend_q     <= pend_n;
      count_q    <= popcount(pend_n);
    end
  end

  assign bus.issue_valid   = (state_q == ST_HOLD);
  assign bus.issue_wf_id   = issue_id_q;
  assign bus.pending_vec   = pend_q;
  assign bus.pending_count = count_q;

endmodule
